// File: rtl/mem_responder.sv
// Memory-port responder: word-organised RAM plus a small MMIO window (GPIO, cycle counter).
// Handshake: the core holds address/data/size/write_enable until ready=1; ready is high for exactly the completion cycle.
module mem_responder #(
   parameter int          RAM_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] data_out,
   input  logic        write_enable,
   input  logic [1:0]  data_size,
   output logic [31:0] data_in,
   output logic        ready,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic        bus_error,
   output logic [1:0]  dbg_state
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   typedef enum logic [1:0] {
      S_ISSUE  = 2'd0,
      S_ISSUE2 = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [31:0]   mem [RAM_WORDS];
   logic [31:0]   cycle_count, word_lo, mmio_off, mmio_rdata, rd_word, wmask;
   logic [29:0]   word_idx;
   logic [1:0]    offset;
   logic [2:0]    size_bytes;
   logic [3:0]    size_be;
   logic [63:0]   wdata64;
   logic [7:0]    be64;
   logic [AW-1:0] idx_a, idx_b, rd_idx;
   logic          size_bad, is_ram, in_mmio, mmio_bad, spans, span_oob, zero_rd, err, go_span;

   function automatic logic [31:0] extract(input logic [63:0] w, input logic [1:0] off,
                                           input logic [1:0] sz);
      logic [63:0] s;
      s = w >> {off, 3'b000};
      case (sz)
         2'b00:   return {24'h0, s[7:0]};
         2'b01:   return {16'h0, s[15:0]};
         default: return s[31:0];
      endcase
   endfunction

   // Access decode: size, mapping, two-word span and the error classes.
   always_comb begin
      offset   = address[1:0];
      word_idx = address[31:2];
      size_bad = (data_size == 2'b11);
      case (data_size)
         2'b00:   begin size_bytes = 3'd1; size_be = 4'b0001; wmask = 32'h0000_00FF; end
         2'b01:   begin size_bytes = 3'd2; size_be = 4'b0011; wmask = 32'h0000_FFFF; end
         default: begin size_bytes = 3'd4; size_be = 4'b1111; wmask = 32'hFFFF_FFFF; end
      endcase
      is_ram   = ({2'b00, word_idx} < 32'(RAM_WORDS));
      mmio_off = address - MMIO_BASE;
      in_mmio  = (mmio_off < 32'd12);
      mmio_bad = in_mmio && ((data_size != 2'b10) || (offset != 2'b00));
      spans    = !size_bad && (({1'b0, offset} + size_bytes) > 3'd4);
      span_oob = is_ram && spans && (({2'b00, word_idx} + 32'd1) >= 32'(RAM_WORDS));
      zero_rd  = size_bad || (!is_ram && !in_mmio) || mmio_bad;
      err      = zero_rd || span_oob;
      go_span  = is_ram && spans && !span_oob;
      idx_a    = word_idx[AW-1:0];
      idx_b    = idx_a + AW'(1);
      rd_idx   = (state == S_ISSUE2) ? idx_b : idx_a;
      rd_word  = mem[rd_idx];
      wdata64  = {32'h0, data_out & wmask} << {offset, 3'b000};
      be64     = {4'h0, size_be} << offset;
      case (mmio_off[3:2])
         2'd0:    mmio_rdata = {24'h0, gpio_out};
         2'd1:    mmio_rdata = {24'h0, gpio_in};
         2'd2:    mmio_rdata = cycle_count;
         default: mmio_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_ISSUE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         S_ISSUE:  state_nxt = go_span ? S_ISSUE2 : S_DONE;
         S_ISSUE2: state_nxt = S_DONE;
         S_DONE: begin
            ready     = 1'b1;
            state_nxt = S_ISSUE;
         end
         default:  state_nxt = S_ISSUE;
      endcase
   end

   assign dbg_state = state;

   // data_in is loaded on the edge into S_DONE so it is valid in the ready cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_in     <= 32'h0;
         gpio_out    <= 8'h0;
         bus_error   <= 1'b0;
         cycle_count <= 32'h0;
         word_lo     <= 32'h0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         case (state)
            S_ISSUE: begin
               word_lo <= rd_word;
               if (err) bus_error <= 1'b1;
               if (!go_span) begin
                  if (zero_rd)      data_in <= 32'h0;
                  else if (in_mmio) data_in <= mmio_rdata;
                  else              data_in <= extract({32'h0, rd_word}, offset, data_size);
               end
            end
            S_ISSUE2: data_in <= extract({rd_word, word_lo}, offset, data_size);
            S_DONE: begin
               if (write_enable && !err && in_mmio && (mmio_off[3:2] == 2'd0))
                  gpio_out <= data_out[7:0];
            end
            default: ;
         endcase
      end
   end

   // Byte-enabled RAM write at the completion edge; a spanning write touches both words.
   always_ff @(posedge clk) begin
      if (!rst && (state == S_DONE) && write_enable && !err && is_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (be64[b]) mem[idx_a][8*b +: 8] <= wdata64[8*b +: 8];
         end
         if (spans) begin
            for (int b = 0; b < 4; b++) begin
               if (be64[4+b]) mem[idx_b][8*b +: 8] <= wdata64[32+8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector tables, a random RAM pass and reset corner cases.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address, data_out, data_in;
   logic        write_enable, ready, bus_error;
   logic [1:0]  data_size, dbg_state;
   logic [7:0]  gpio_in, gpio_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [1:0]  sz;
      logic        chk;
      logic [31:0] exp_rd;
      int          lat;
      logic [7:0]  exp_gpio;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   mem_responder dut (
      .clk(clk), .rst(rst), .address(address), .data_out(data_out),
      .write_enable(write_enable), .data_size(data_size), .data_in(data_in),
      .ready(ready), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .bus_error(bus_error), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h", nm, id, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w, input logic we_i,
                               input logic [1:0] sz, input logic chk, input logic [31:0] e,
                               input int lat, input logic [7:0] g, input logic er);
      vec_t v;
      v.addr = a; v.wdata = w; v.we = we_i; v.sz = sz; v.chk = chk;
      v.exp_rd = e; v.lat = lat; v.exp_gpio = g; v.exp_err = er;
      return v;
   endfunction

   // Drive one access starting in S_ISSUE; returns one cycle after the ready cycle, back in S_ISSUE.
   task automatic access(input int id, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we_i, input logic [1:0] sz, input logic chk,
                         input logic [31:0] exp_rd, input int exp_lat, input logic exp_err,
                         output logic [31:0] rd);
      int   lat;
      logic got;
      address = addr; data_out = wd; write_enable = we_i; data_size = sz;
      if (chk) exp_q.push_back(exp_rd);
      lat = 0;
      got = 1'b0;
      rd  = 32'h0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (ready) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout[%0d] got no ready want ready within 10 cycles", id);
         if (chk) void'(exp_q.pop_front());
      end else begin
         rd = data_in;
         if (chk) check("read_data", id, data_in, exp_q.pop_front());
         check("latency", id, 32'(lat), 32'(exp_lat));
         check("bus_error", id, {31'h0, bus_error}, {31'h0, exp_err});
         @(posedge clk);
         #1;
         check("ready_single", id, {31'h0, ready}, 32'h0);
      end
   endtask

   task automatic run_vecs(input int base);
      logic [31:0] rd;
      for (int i = 0; i < vq.size(); i++) begin
         access(base + i, vq[i].addr, vq[i].wdata, vq[i].we, vq[i].sz, vq[i].chk,
                vq[i].exp_rd, vq[i].lat, vq[i].exp_err, rd);
         check("gpio_out", base + i, {24'h0, gpio_out}, {24'h0, vq[i].exp_gpio});
      end
   endtask

   initial begin
      logic [31:0] rd, c1, c2;
      logic [31:0] model [8];
      logic [1:0]  off;

      rst = 1'b1;
      gpio_in = 8'h3C;
      address = 32'h100; data_out = 32'h0; write_enable = 1'b0; data_size = 2'b10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 0, {31'h0, ready}, 32'h0);
      check("rst_data_in", 0, data_in, 32'h0);
      check("rst_gpio_out", 0, {24'h0, gpio_out}, 32'h0);
      check("rst_bus_error", 0, {31'h0, bus_error}, 32'h0);
      check("rst_state", 0, {30'h0, dbg_state}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Functional table: aligned, byte lanes, spanning, MMIO.
      vq.delete();
      vq.push_back(mk(32'h100, 32'hDEADBEEF, 1, 2'b10, 0, 32'h0,        2, 8'h00, 0));
      vq.push_back(mk(32'h100, 32'h0,        0, 2'b10, 1, 32'hDEADBEEF, 2, 8'h00, 0));
      vq.push_back(mk(32'h200, 32'h11223344, 1, 2'b10, 0, 32'h0,        2, 8'h00, 0));
      vq.push_back(mk(32'h201, 32'h000000AA, 1, 2'b00, 1, 32'h00000033, 2, 8'h00, 0));
      vq.push_back(mk(32'h200, 32'h0,        0, 2'b10, 1, 32'h1122AA44, 2, 8'h00, 0));
      vq.push_back(mk(32'h202, 32'h0,        0, 2'b01, 1, 32'h00001122, 2, 8'h00, 0));
      vq.push_back(mk(32'h000, 32'h44332211, 1, 2'b10, 0, 32'h0,        2, 8'h00, 0));
      vq.push_back(mk(32'h004, 32'h88776655, 1, 2'b10, 0, 32'h0,        2, 8'h00, 0));
      vq.push_back(mk(32'h003, 32'h0,        0, 2'b10, 1, 32'h77665544, 3, 8'h00, 0));
      vq.push_back(mk(32'h003, 32'h0000BEEF, 1, 2'b01, 1, 32'h00005544, 3, 8'h00, 0));
      vq.push_back(mk(32'h000, 32'h0,        0, 2'b10, 1, 32'hEF332211, 2, 8'h00, 0));
      vq.push_back(mk(32'h004, 32'h0,        0, 2'b10, 1, 32'h887766BE, 2, 8'h00, 0));
      vq.push_back(mk(32'h007, 32'h0,        0, 2'b00, 1, 32'h00000088, 2, 8'h00, 0));
      vq.push_back(mk(32'h001, 32'h0,        0, 2'b10, 1, 32'hBEEF3322, 3, 8'h00, 0));
      vq.push_back(mk(32'h040, 32'hCAFEF00D, 1, 2'b10, 0, 32'h0,        2, 8'h00, 0));
      vq.push_back(mk(32'h3FFC, 32'hA1B2C3D4, 1, 2'b10, 0, 32'h0,       2, 8'h00, 0));
      vq.push_back(mk(32'hFFFF0000, 32'h000000A5, 1, 2'b10, 1, 32'h0,   2, 8'hA5, 0));
      vq.push_back(mk(32'hFFFF0000, 32'h0,   0, 2'b10, 1, 32'h000000A5, 2, 8'hA5, 0));
      vq.push_back(mk(32'hFFFF0004, 32'h0,   0, 2'b10, 1, 32'h0000003C, 2, 8'hA5, 0));
      vq.push_back(mk(32'hFFFF0004, 32'hDEAD, 1, 2'b10, 1, 32'h0000003C, 2, 8'hA5, 0));
      vq.push_back(mk(32'h3FFD, 32'h0,       0, 2'b01, 1, 32'h0000B2C3, 2, 8'hA5, 0));
      vq.push_back(mk(32'h3FFF, 32'h0,       0, 2'b00, 1, 32'h000000A1, 2, 8'hA5, 0));
      run_vecs(100);

      // Random words against a local model, then random byte reads.
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom();
         access(200 + i, 32'h400 + 32'(4 * i), model[i], 1, 2'b10, 0, 32'h0, 2, 0, rd);
      end
      for (int i = 0; i < 8; i++) begin
         access(210 + i, 32'h400 + 32'(4 * i), 32'h0, 0, 2'b10, 1, model[i], 2, 0, rd);
      end
      for (int i = 0; i < 6; i++) begin
         int k;
         k = $urandom_range(0, 7);
         off = 2'($urandom_range(0, 3));
         access(220 + i, 32'h400 + 32'(4 * k) + {30'h0, off}, 32'h0, 0, 2'b00, 1,
                (model[k] >> (8 * off)) & 32'hFF, 2, 0, rd);
      end

      // Cycle counter: two reads whose sample cycles are 10 apart.
      access(300, 32'hFFFF0008, 32'h0, 0, 2'b10, 0, 32'h0, 2, 0, c1);
      repeat (8) @(posedge clk);
      #1;
      access(301, 32'hFFFF0008, 32'h0, 0, 2'b10, 0, 32'h0, 2, 0, c2);
      check("cycle_delta", 302, c2 - c1, 32'd10);

      // Error cases; bus_error is sticky from the first one on.
      vq.delete();
      vq.push_back(mk(32'h00100000, 32'h0,  0, 2'b10, 1, 32'h0,        2, 8'hA5, 1));
      vq.push_back(mk(32'h100, 32'h0,       0, 2'b10, 1, 32'hDEADBEEF, 2, 8'hA5, 1));
      vq.push_back(mk(32'hFFFF0001, 32'h5A, 1, 2'b00, 1, 32'h0,        2, 8'hA5, 1));
      vq.push_back(mk(32'h100, 32'h0,       0, 2'b11, 1, 32'h0,        2, 8'hA5, 1));
      vq.push_back(mk(32'hFFFF0000, 32'h0,  0, 2'b01, 1, 32'h0,        2, 8'hA5, 1));
      vq.push_back(mk(32'hFFFF000C, 32'h0,  0, 2'b10, 1, 32'h0,        2, 8'hA5, 1));
      vq.push_back(mk(32'h3FFE, 32'h0,      0, 2'b10, 1, 32'h0000A1B2, 2, 8'hA5, 1));
      vq.push_back(mk(32'h3FFE, 32'hFFFFFFFF, 1, 2'b10, 1, 32'h0000A1B2, 2, 8'hA5, 1));
      vq.push_back(mk(32'h3FFC, 32'h0,      0, 2'b10, 1, 32'hA1B2C3D4, 2, 8'hA5, 1));
      run_vecs(400);

      // Reset while a write sits in S_ISSUE.
      address = 32'h40; data_out = 32'h12345678; write_enable = 1'b1; data_size = 2'b10;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_issue_ready", 500, {31'h0, ready}, 32'h0);
      check("rst_issue_gpio", 500, {24'h0, gpio_out}, 32'h0);
      check("rst_issue_err", 500, {31'h0, bus_error}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      access(501, 32'h40, 32'h0, 0, 2'b10, 1, 32'hCAFEF00D, 2, 0, rd);

      // Reset landing on the S_DONE commit edge must drop the write.
      address = 32'h40; data_out = 32'h12345678; write_enable = 1'b1; data_size = 2'b10;
      @(posedge clk);
      #1;
      check("pre_rst_done_state", 502, {30'h0, dbg_state}, 32'h2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_done_ready", 503, {31'h0, ready}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      access(504, 32'h40, 32'h0, 0, 2'b10, 1, 32'hCAFEF00D, 2, 0, rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
